// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_reset_sequencer: sequences SDRAM and core resets from PLL lock status. |
// | Optional lock-loss counter: define PLL_RESET_LOCK_LOSS_COUNT_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SDR_POWERUP_CYCLES = 5000,
  parameter int SOFT_RST_CYCLES    = 16
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       sdr_rst,
  output logic       core_rst,
  output logic       running,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_AB     = (LOCK_STABLE_CYCLES > SDR_POWERUP_CYCLES) ?
                              LOCK_STABLE_CYCLES : SDR_POWERUP_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > SOFT_RST_CYCLES) ? MAX_AB : SOFT_RST_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  // Terminal values: the first cycle in a state is count 0.
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(SDR_POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST    = CNT_W'(SOFT_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_STABLE  = 3'd1,
    ST_POWERUP = 3'd2,
    ST_RUN     = 3'd3,
    ST_SOFT    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync1_d;
  logic             locked_s_q, locked_s_d;
  logic             sdr_rst_q, sdr_rst_d;
  logic             core_rst_q, core_rst_d;
  logic             running_q, running_d;

  always_comb begin
    sync1_d    = pll_locked;
    locked_s_d = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);

    case (state_q)
      ST_HOLD: begin
        cnt_d = '0;
        if (locked_s_q) begin
          state_d = ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (!locked_s_q) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_POWERUP;
          cnt_d   = '0;
        end
      end
      ST_POWERUP: begin
        if (!locked_s_q) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == POWERUP_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        // Lock loss takes priority over a soft reset request.
        if (!locked_s_q) begin
          state_d = ST_HOLD;
        end else if (soft_rst_req) begin
          state_d = ST_SOFT;
        end
      end
      ST_SOFT: begin
        if (!locked_s_q) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == SOFT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode the next state so they change with the state itself.
    sdr_rst_d  = (state_d == ST_HOLD) || (state_d == ST_STABLE);
    core_rst_d = (state_d != ST_RUN);
    running_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      sdr_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      locked_s_q <= locked_s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sdr_rst_q  <= sdr_rst_d;
      core_rst_q <= core_rst_d;
      running_q  <= running_d;
    end
  end

  assign sdr_rst  = sdr_rst_q;
  assign core_rst = core_rst_q;
  assign running  = running_q;

`ifdef PLL_RESET_LOCK_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;
  logic       lock_loss_evt;

  // Every non-HOLD state falls back to HOLD when the lock drops.
  assign lock_loss_evt = (state_q != ST_HOLD) && !locked_s_q;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_loss_evt && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= 8'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_count = loss_cnt_q;
`else
  assign lock_loss_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// Directed bench for pll_reset_sequencer with LOCK=8, POWERUP=16, SOFT=4.
// Cycle k is the sys_clk edge at which pll_locked is first sampled high, plus k.
module tb_pll_reset_sequencer;

  logic       sys_clk;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_rst_req;
  logic       sdr_rst;
  logic       core_rst;
  logic       running;
  logic [7:0] lock_loss_count;

`ifdef PLL_RESET_LOCK_LOSS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int         n_cmp;
  int         n_err;
  logic [7:0] exp_cnt;
  logic [2:0] exp_o;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(8),
    .SDR_POWERUP_CYCLES(16),
    .SOFT_RST_CYCLES   (4)
  ) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .pll_locked     (pll_locked),
    .soft_rst_req   (soft_rst_req),
    .sdr_rst        (sdr_rst),
    .core_rst       (core_rst),
    .running        (running),
    .lock_loss_count(lock_loss_count)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    soft_rst_req = 1'b0;
    repeat (2) step;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n        = 1'b1;
    pll_locked   = 1'b0;
    soft_rst_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({sdr_rst, core_rst, running} !== 3'b110) begin
        n_err++;
        $display("FAIL reset_outs step %0d: got %b want 110", i, {sdr_rst, core_rst, running});
      end
      n_cmp++;
      if (lock_loss_count !== 8'd0) begin
        n_err++;
        $display("FAIL reset_count step %0d: got %0d want 0", i, lock_loss_count);
      end
      step;
    end
  endtask

  task automatic test_power_up;
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step;
      exp_o = {k < 10, k < 26, k >= 26};
      n_cmp++;
      if ({sdr_rst, core_rst, running} !== exp_o) begin
        n_err++;
        $display("FAIL power_up cyc %0d: got %b want %b", k, {sdr_rst, core_rst, running}, exp_o);
      end
    end
    exp_cnt = 8'd0;
    n_cmp++;
    if (lock_loss_count !== 8'd0) begin
      n_err++;
      $display("FAIL power_up_count: got %0d want 0", lock_loss_count);
    end
  endtask

  task automatic test_soft_reset;
    // Second request at j=3 arrives while already in SOFT and must be ignored.
    for (int j = 1; j <= 7; j++) begin
      soft_rst_req = (j == 1) || (j == 3);
      step;
      exp_o = {1'b0, j <= 4, j > 4};
      n_cmp++;
      if ({sdr_rst, core_rst, running} !== exp_o) begin
        n_err++;
        $display("FAIL soft_reset cyc %0d: got %b want %b", j, {sdr_rst, core_rst, running}, exp_o);
      end
    end
    soft_rst_req = 1'b0;
  endtask

  task automatic test_lock_loss_run;
    // Soft request lands on the same cycle the FSM first sees the lock drop.
    for (int j = 1; j <= 6; j++) begin
      pll_locked   = 1'b0;
      soft_rst_req = (j == 3);
      step;
      exp_o = (j < 3) ? 3'b001 : 3'b110;
      n_cmp++;
      if ({sdr_rst, core_rst, running} !== exp_o) begin
        n_err++;
        $display("FAIL lock_loss cyc %0d: got %b want %b", j, {sdr_rst, core_rst, running}, exp_o);
      end
    end
    soft_rst_req = 1'b0;
    exp_cnt = 8'd1;
    n_cmp++;
    if (lock_loss_count !== (CNT_EN ? exp_cnt : 8'd0)) begin
      n_err++;
      $display("FAIL lock_loss_count: got %0d want %0d", lock_loss_count, CNT_EN ? exp_cnt : 8'd0);
    end
    pll_locked = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step;
      exp_o = {k < 10, k < 26, k >= 26};
      n_cmp++;
      if ({sdr_rst, core_rst, running} !== exp_o) begin
        n_err++;
        $display("FAIL relock cyc %0d: got %b want %b", k, {sdr_rst, core_rst, running}, exp_o);
      end
    end
    n_cmp++;
    if (lock_loss_count !== (CNT_EN ? exp_cnt : 8'd0)) begin
      n_err++;
      $display("FAIL relock_count: got %0d want %0d", lock_loss_count, CNT_EN ? exp_cnt : 8'd0);
    end
  endtask

  task automatic test_async_reset;
    apply_reset;
    pll_locked = 1'b1;
    repeat (16) step;
    n_cmp++;
    if ({sdr_rst, core_rst, running} !== 3'b010) begin
      n_err++;
      $display("FAIL async_pre in powerup: got %b want 010", {sdr_rst, core_rst, running});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sdr_rst, core_rst, running} !== 3'b110) begin
      n_err++;
      $display("FAIL async_outs: got %b want 110", {sdr_rst, core_rst, running});
    end
    n_cmp++;
    if (lock_loss_count !== 8'd0) begin
      n_err++;
      $display("FAIL async_count: got %0d want 0", lock_loss_count);
    end
    step;
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step;
      exp_o = {k < 10, k < 26, k >= 26};
      n_cmp++;
      if ({sdr_rst, core_rst, running} !== exp_o) begin
        n_err++;
        $display("FAIL async_reseq cyc %0d: got %b want %b", k, {sdr_rst, core_rst, running}, exp_o);
      end
    end
  endtask

  task automatic test_unstable_lock;
    apply_reset;
    for (int k = 0; k < 21; k++) begin
      pll_locked = (k < 5) || (k >= 8);
      step;
      exp_o = {k < 18, 1'b1, 1'b0};
      n_cmp++;
      if ({sdr_rst, core_rst, running} !== exp_o) begin
        n_err++;
        $display("FAIL unstable cyc %0d: got %b want %b", k, {sdr_rst, core_rst, running}, exp_o);
      end
    end
    exp_cnt = 8'd1;
    n_cmp++;
    if (lock_loss_count !== (CNT_EN ? exp_cnt : 8'd0)) begin
      n_err++;
      $display("FAIL unstable_count: got %0d want %0d", lock_loss_count, CNT_EN ? exp_cnt : 8'd0);
    end
  endtask

  task automatic test_saturation;
    // Pattern 1,1,0,0 enters STABLE and drops out once every 4 cycles,
    // with the n-th loss at cycle 4n.
    apply_reset;
    for (int k = 0; k < 1048; k++) begin
      pll_locked = ((k % 4) < 2);
      step;
      if (k == 399 || k == 1019) begin
        exp_cnt = (k == 399) ? 8'd99 : 8'd254;
        n_cmp++;
        if (lock_loss_count !== (CNT_EN ? exp_cnt : 8'd0)) begin
          n_err++;
          $display("FAIL sat_progress cyc %0d: got %0d want %0d", k, lock_loss_count,
                   CNT_EN ? exp_cnt : 8'd0);
        end
      end
    end
    exp_cnt = 8'd255;
    n_cmp++;
    if (lock_loss_count !== (CNT_EN ? exp_cnt : 8'd0)) begin
      n_err++;
      $display("FAIL sat_final: got %0d want %0d", lock_loss_count, CNT_EN ? exp_cnt : 8'd0);
    end
    n_cmp++;
    if ({sdr_rst, core_rst, running} !== 3'b110) begin
      n_err++;
      $display("FAIL sat_outs: got %b want 110", {sdr_rst, core_rst, running});
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    exp_cnt      = 8'd0;
    exp_o        = 3'b000;
    rst_n        = 1'b1;
    pll_locked   = 1'b0;
    soft_rst_req = 1'b0;
    test_reset;
    test_power_up;
    test_soft_reset;
    test_lock_loss_run;
    test_async_reset;
    test_unstable_lock;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Consumes the PLL lock indication and generates sequenced synchronous resets for the system clock domain. It sits directly downstream of the system PLL and is clocked by the PLL's sys_clk output. It waits for a stable lock, releases the SDRAM controller reset, then waits out the SDRAM power-up interval before releasing the CPU core reset. It also re-sequences on lock loss and supports a core-only soft reset.

Parameters:
LOCK_STABLE_CYCLES, 1024, cycles locked_s must stay high before sdr_rst releases (>=2)
SDR_POWERUP_CYCLES, 5000, cycles between sdr_rst release and core_rst release (100 us at 50 MHz, >=2)
SOFT_RST_CYCLES, 16, core_rst assertion length for a soft reset (>=2)

Ports:
sys_clk  in  1  system clock from PLL clk0
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL locked, asynchronous to sys_clk
soft_rst_req  in  1  sys_clk-synchronous request for a core-only reset; level sampled each cycle
sdr_rst  out  1  active-high synchronous reset to the SDRAM controller
core_rst  out  1  active-high synchronous reset to the CPU core and peripherals
running  out  1  high when state==RUN
lock_loss_count  out  8  saturating count of lock-loss events

Behaviour:
- Reset (rst_n=0, async): state=HOLD, sync flops=0, counter=0, sdr_rst=1, core_rst=1, running=0, lock_loss_count=0. Deassertion of rst_n takes effect at the next sys_clk edge.
- pll_locked passes through a 2-flop synchronizer to produce locked_s. This adds 2 cycles of latency.
- All outputs are registered. An output changes in the first cycle the new state is visible.
- Single down-counter (or up-counter), width clog2 of the largest parameter. Reload to 0 on every state entry.
- HOLD: sdr_rst=1, core_rst=1. When locked_s=1, go to STABLE.
- STABLE: count cycles. If locked_s=0, go to HOLD. On the Nth cycle (N=LOCK_STABLE_CYCLES, first STABLE cycle counted as 1), go to POWERUP. sdr_rst=0 from the first POWERUP cycle.
- POWERUP: sdr_rst=0, core_rst=1. After SDR_POWERUP_CYCLES cycles, go to RUN. core_rst=0 and running=1 from the first RUN cycle.
- RUN: sdr_rst=0, core_rst=0. When soft_rst_req=1, go to SOFT.
- SOFT: core_rst=1, sdr_rst=0, running=0. After SOFT_RST_CYCLES cycles, return to RUN. soft_rst_req is ignored while in SOFT.
- soft_rst_req is ignored in HOLD, STABLE and POWERUP.
- Lock loss: locked_s=0 in STABLE, POWERUP, RUN or SOFT goes to HOLD. The next cycle shows sdr_rst=1, core_rst=1, running=0. Each such transition increments lock_loss_count, saturating at 255. locked_s=0 while in HOLD does not count.
- Simultaneous events: lock loss beats soft_rst_req. Lock loss beats counter expiry.
- Glitch: a 1-cycle locked_s drop in RUN still forces a full re-sequence (HOLD→STABLE→POWERUP→RUN).
- rst_n asserted mid-sequence: immediate return to reset values, including lock_loss_count.

Optional Feature:
Macro: PLL_RESET_LOCK_LOSS_COUNT_EN.
- Defined: lock_loss_count is implemented as described above.
- Not defined: the counter logic is omitted and lock_loss_count is tied to 8'd0. All other behaviour is identical.

Test Plan:
Parameters for all tests: LOCK_STABLE_CYCLES=8, SDR_POWERUP_CYCLES=16, SOFT_RST_CYCLES=4.
1. Power-up: release rst_n, raise pll_locked at cycle 0 -> sdr_rst falls at cycle 2+8=10; core_rst falls and running rises at cycle 26; lock_loss_count=0.
2. Unstable lock: pll_locked high for 5 cycles, low for 3, then high -> sdr_rst never falls during the first attempt; sdr_rst falls 10 cycles after the final rise; lock_loss_count=1 with the macro, 0 without.
3. Soft reset: in RUN, pulse soft_rst_req for 1 cycle -> core_rst high for exactly 4 cycles starting the next cycle, sdr_rst stays 0, then running=1 again.
4. Lock loss in RUN concurrent with soft_rst_req -> within 3 cycles of the pll_locked fall both resets =1 and state=HOLD; a re-lock re-sequences with the same 8/16-cycle timing; count increments by 1.
5. Saturation (macro defined): force 260 lock-loss events from STABLE -> lock_loss_count holds at 255.
6. Async reset mid-POWERUP: assert rst_n=0 with no clock edge -> sdr_rst=1, core_rst=1, lock_loss_count=0 immediately; full sequence repeats after release.
